// File: rtl/l2_cache_nway_control_if.sv
// CPU-side request port and cacheline-adaptor handshake of the N-way L2 controller.
// mem_read/mem_write are held with a stable set_index until the one-cycle mem_resp;
// pmem_read/pmem_write are held until the cycle in which pmem_resp is sampled high.
interface l2_cache_nway_control_if #(
  parameter int SETS = 8
);
  logic                    mem_read;
  logic                    mem_write;
  logic [$clog2(SETS)-1:0] set_index;
  logic                    mem_resp;
  logic                    pmem_read;
  logic                    pmem_write;
  logic                    pmem_resp;

  modport master (
    output mem_read, mem_write, set_index, pmem_resp,
    input  mem_resp, pmem_read, pmem_write
  );

  modport slave (
    input  mem_read, mem_write, set_index, pmem_resp,
    output mem_resp, pmem_read, pmem_write
  );
endinterface

// File: rtl/l2_cache_nway_control.sv
// Control FSM of the WAYS-way write-back/write-allocate L2: tree-PLRU, invalid-first victim.
// Define L2_CTRL_PERF_CNT_EN to build the saturating hit/miss/write-back counters.
module l2_cache_nway_control #(
  parameter int WAYS = 4,
  parameter int SETS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  l2_cache_nway_control_if.slave        bus,
  input  logic                          hit,
  input  logic [WAYS-1:0]               way_hit,
  input  logic [WAYS-1:0]               valid_out,
  input  logic [WAYS-1:0]               dirty_out,
  output logic [WAYS-1:0]               way_load,
  output logic [WAYS-1:0]               valid_load,
  output logic [WAYS-1:0]               valid_in,
  output logic [WAYS-1:0]               dirty_load,
  output logic [WAYS-1:0]               dirty_in,
  output logic [WAYS-1:0][1:0]          data_write_sel,
  output logic [$clog2(WAYS)-1:0]       way_sel,
  output logic                          pmem_address_sel,
  output logic [31:0]                   hit_count,
  output logic [31:0]                   miss_count,
  output logic [31:0]                   wb_count,
  output logic [1:0]                    state_dbg
);
  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic [1:0] {IDLE, COMPARE_TAG, WRITE_BACK, ALLOCATE} state_t;

  state_t           state;
  logic [WAY_W-1:0] victim;
  logic [WAYS-2:0]  plru [SETS];

  logic [WAYS-2:0]  plru_cur;
  logic [WAYS-2:0]  plru_upd;
  logic [WAY_W-1:0] hit_idx;
  logic [WAY_W-1:0] plru_victim;
  logic [WAY_W-1:0] inv_idx;
  logic             inv_found;
  logic [WAY_W-1:0] victim_next;
  logic             node_bit;
  logic             dir;
  int               n_vic;
  int               n_upd;

  assign state_dbg = state;
  assign plru_cur  = plru[bus.set_index];

  // Victim search walks the heap from the root; the update walks the hit path and points away.
  always_comb begin
    hit_idx     = '0;
    inv_found   = 1'b0;
    inv_idx     = '0;
    plru_upd    = plru_cur;
    node_bit    = 1'b0;
    dir         = 1'b0;
    n_vic       = 1;
    n_upd       = 1;
    for (int i = 0; i < WAYS; i++) begin
      if (way_hit[i]) hit_idx = WAY_W'(i);
    end
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_out[i]) begin
        inv_found = 1'b1;
        inv_idx   = WAY_W'(i);
      end
    end
    for (int l = 0; l < WAY_W; l++) begin
      node_bit = 1'b0;
      for (int k = 1; k < WAYS; k++) begin
        if (k == n_vic) node_bit = plru_cur[k-1];
      end
      n_vic = 2 * n_vic + (node_bit ? 1 : 0);
      dir = hit_idx[WAY_W-1-l];
      for (int k = 1; k < WAYS; k++) begin
        if (k == n_upd) plru_upd[k-1] = ~dir;
      end
      n_upd = 2 * n_upd + (dir ? 1 : 0);
    end
    plru_victim = WAY_W'(n_vic - WAYS);
    victim_next = inv_found ? inv_idx : plru_victim;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      victim <= '0;
      for (int s = 0; s < SETS; s++) plru[s] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.mem_read || bus.mem_write) state <= COMPARE_TAG;
        end
        COMPARE_TAG: begin
          if (hit) begin
            plru[bus.set_index] <= plru_upd;
            state               <= IDLE;
          end else begin
            victim <= victim_next;
            state  <= dirty_out[victim_next] ? WRITE_BACK : ALLOCATE;
          end
        end
        WRITE_BACK: begin
          if (bus.pmem_resp) state <= ALLOCATE;
        end
        ALLOCATE: begin
          if (bus.pmem_resp) state <= COMPARE_TAG;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode from state so an asynchronous reset drops them immediately.
  always_comb begin
    bus.mem_resp     = 1'b0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    way_load         = '0;
    valid_load       = '0;
    valid_in         = '0;
    dirty_load       = '0;
    dirty_in         = '0;
    data_write_sel   = '0;
    way_sel          = '0;
    pmem_address_sel = 1'b0;
    case (state)
      COMPARE_TAG: begin
        if (hit) begin
          bus.mem_resp = 1'b1;
          way_sel      = hit_idx;
          if (bus.mem_write) begin
            dirty_load[hit_idx]     = 1'b1;
            dirty_in[hit_idx]       = 1'b1;
            data_write_sel[hit_idx] = 2'd1;
          end
        end
      end
      WRITE_BACK: begin
        bus.pmem_write   = 1'b1;
        way_sel          = victim;
        pmem_address_sel = 1'b1;
      end
      ALLOCATE: begin
        bus.pmem_read          = 1'b1;
        way_load[victim]       = 1'b1;
        valid_load[victim]     = 1'b1;
        valid_in[victim]       = 1'b1;
        dirty_load[victim]     = 1'b1;
        data_write_sel[victim] = 2'd2;
      end
      default: ;
    endcase
  end

`ifdef L2_CTRL_PERF_CNT_EN
  logic is_cmp;
  logic wb_entry;
  assign is_cmp   = (state == COMPARE_TAG);
  assign wb_entry = is_cmp && !hit && dirty_out[victim_next];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (is_cmp && hit && (hit_count != 32'hFFFF_FFFF))    hit_count  <= hit_count + 32'd1;
      if (is_cmp && !hit && (miss_count != 32'hFFFF_FFFF))  miss_count <= miss_count + 32'd1;
      if (wb_entry && (wb_count != 32'hFFFF_FFFF))          wb_count   <= wb_count + 32'd1;
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
  assign wb_count   = '0;
`endif
endmodule

// File: tb/tb_l2_cache_nway_control.sv
// Bench for l2_cache_nway_control: behavioural tag/valid/dirty arrays, a latency-3 pmem
// responder, and a scoreboard that checks every mem_resp and pmem request start.
module tb_l2_cache_nway_control;
  localparam int WAYS  = 4;
  localparam int SETS  = 8;
  localparam int WAY_W = 2;
  localparam int W     = 34;
  localparam int PMEM_LAT = 3;
`ifdef L2_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  hit;
  logic [WAYS-1:0]       way_hit, valid_out, dirty_out;
  logic [WAYS-1:0]       way_load, valid_load, valid_in, dirty_load, dirty_in;
  logic [WAYS-1:0][1:0]  data_write_sel;
  logic [WAY_W-1:0]      way_sel;
  logic                  pmem_address_sel;
  logic [31:0]           hit_count, miss_count, wb_count;
  logic [1:0]            state_dbg;

  int n_total = 0;
  int n_pass  = 0;

  l2_cache_nway_control_if #(.SETS(SETS)) bus ();

  l2_cache_nway_control #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .hit(hit), .way_hit(way_hit), .valid_out(valid_out), .dirty_out(dirty_out),
    .way_load(way_load), .valid_load(valid_load), .valid_in(valid_in),
    .dirty_load(dirty_load), .dirty_in(dirty_in), .data_write_sel(data_write_sel),
    .way_sel(way_sel), .pmem_address_sel(pmem_address_sel),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // datapath arrays driven by the controller's one-hot controls
  logic [7:0]      req_tag;
  logic [7:0]      dp_tag   [SETS][WAYS];
  logic [WAYS-1:0] dp_valid [SETS];
  logic [WAYS-1:0] dp_dirty [SETS];

  initial begin
    for (int s = 0; s < SETS; s++) begin
      dp_valid[s] = '0;
      dp_dirty[s] = '0;
      for (int w = 0; w < WAYS; w++) dp_tag[s][w] = '0;
    end
  end

  always_comb begin
    for (int i = 0; i < WAYS; i++)
      way_hit[i] = dp_valid[bus.set_index][i] && (dp_tag[bus.set_index][i] == req_tag);
  end
  assign hit       = |way_hit;
  assign valid_out = dp_valid[bus.set_index];
  assign dirty_out = dp_dirty[bus.set_index];

  always @(posedge clk) begin
    for (int i = 0; i < WAYS; i++) begin
      if (way_load[i])   dp_tag[bus.set_index][i]   <= req_tag;
      if (valid_load[i]) dp_valid[bus.set_index][i] <= valid_in[i];
      if (dirty_load[i]) dp_dirty[bus.set_index][i] <= dirty_in[i];
    end
  end

  // pmem responder
  int wait_cnt = 0;
  initial begin
    bus.pmem_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.pmem_resp) begin
        bus.pmem_resp = 1'b0;
        wait_cnt = 0;
      end else if (bus.pmem_read || bus.pmem_write) begin
        wait_cnt++;
        if (wait_cnt >= PMEM_LAT) bus.pmem_resp = 1'b1;
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic         prev_pr = 1'b0;
  logic         prev_pw = 1'b0;
  logic [W-1:0] act_v, exp_v;

  function automatic logic [W-1:0] ev(bit resp, bit pr, bit pw, bit asel, int ws,
                                      logic [3:0] wl, logic [3:0] vl, logic [3:0] vi,
                                      logic [3:0] dl, logic [3:0] di, logic [7:0] dws);
    return {resp, pr, pw, asel, 2'(ws), wl, vl, vi, dl, di, dws};
  endfunction

  always @(negedge clk) begin
    if (!rst && (bus.mem_resp || (bus.pmem_read && !prev_pr) || (bus.pmem_write && !prev_pw))) begin
      act_v = {bus.mem_resp, bus.pmem_read, bus.pmem_write, pmem_address_sel, way_sel,
               way_load, valid_load, valid_in, dirty_load, dirty_in, data_write_sel};
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL event: unexpected output %h at %0t", act_v, $time);
      end else begin
        exp_v = exp_q.pop_front();
        if (act_v === exp_v) n_pass++;
        else $display("FAIL event: got %h expected %h at %0t", act_v, exp_v, $time);
      end
    end
    prev_pr = bus.pmem_read;
    prev_pw = bus.pmem_write;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // driver tasks
  task automatic push_hit(input int w, input bit wr);
    logic [3:0] oh;
    logic [7:0] d;
    oh = 4'b0001 << w;
    d  = wr ? (8'b01 << (2 * w)) : 8'h00;
    exp_q.push_back(ev(1, 0, 0, 0, w, 4'h0, 4'h0, 4'h0, wr ? oh : 4'h0, wr ? oh : 4'h0, d));
  endtask

  task automatic push_alloc(input int v);
    logic [3:0] oh;
    oh = 4'b0001 << v;
    exp_q.push_back(ev(0, 1, 0, 0, 0, oh, oh, oh, oh, 4'h0, 8'b10 << (2 * v)));
  endtask

  task automatic push_wb(input int v);
    exp_q.push_back(ev(0, 0, 1, 1, v, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00));
  endtask

  task automatic req(input logic [2:0] s, input logic [7:0] t, input bit rd, input bit wr);
    bit got;
    bus.set_index = s;
    req_tag       = t;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (bus.mem_resp) got = 1'b1;
    end
    if (!got) begin
      n_total++;
      $display("FAIL req_timeout: set %0d tag %0h no mem_resp", s, t);
    end
    @(posedge clk);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  task automatic miss_fill(input logic [2:0] s, input logic [7:0] t, input int v);
    push_alloc(v);
    push_hit(v, 1'b0);
    req(s, t, 1'b1, 1'b0);
  endtask

  initial begin
    bit got;
    rst           = 1'b1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.set_index = '0;
    req_tag       = '0;
    #2;
    chk("reset_state", 32'(state_dbg), 32'd0);
    chk("reset_mem_resp", 32'(bus.mem_resp), 32'd0);
    chk("reset_pmem_rw", {30'd0, bus.pmem_read, bus.pmem_write}, 32'd0);
    chk("reset_way_load", 32'(way_load), 32'd0);
    chk("reset_hit_count", hit_count, 32'd0);
    chk("reset_miss_count", miss_count, 32'd0);
    chk("reset_wb_count", wb_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // cold miss on set 3 fills way 0
    miss_fill(3'd3, 8'hA0, 0);
    chk("cold_miss_count", miss_count, PERF ? 32'd1 : 32'd0);
    chk("cold_hit_count", hit_count, PERF ? 32'd1 : 32'd0);

    // invalid-first fills ways 1..3, then hits 0,1,2,3 leave PLRU pointing at way 0
    miss_fill(3'd3, 8'hA1, 1);
    miss_fill(3'd3, 8'hA2, 2);
    miss_fill(3'd3, 8'hA3, 3);
    for (int w = 0; w < 4; w++) begin
      push_hit(w, 1'b0);
      req(3'd3, 8'hA0 + 8'(w), 1'b1, 1'b0);
    end
    miss_fill(3'd3, 8'hB0, 0);
    push_hit(0, 1'b0);
    req(3'd3, 8'hB0, 1'b1, 1'b0);
    miss_fill(3'd3, 8'hB1, 2);

    // write hit on way 2 of set 5
    miss_fill(3'd5, 8'hC0, 0);
    miss_fill(3'd5, 8'hC1, 1);
    miss_fill(3'd5, 8'hC2, 2);
    push_hit(2, 1'b1);
    req(3'd5, 8'hC2, 1'b0, 1'b1);
    chk("write_hit_count", hit_count, PERF ? 32'd15 : 32'd0);

    // dirty PLRU victim way 1 in set 1
    miss_fill(3'd1, 8'hD0, 0);
    miss_fill(3'd1, 8'hD1, 1);
    miss_fill(3'd1, 8'hD2, 2);
    miss_fill(3'd1, 8'hD3, 3);
    push_hit(1, 1'b1);
    req(3'd1, 8'hD1, 1'b0, 1'b1);
    push_hit(0, 1'b0);
    req(3'd1, 8'hD0, 1'b1, 1'b0);
    push_hit(3, 1'b0);
    req(3'd1, 8'hD3, 1'b1, 1'b0);
    push_wb(1);
    miss_fill(3'd1, 8'hE0, 1);
    chk("dirty_wb_count", wb_count, PERF ? 32'd1 : 32'd0);

    // read and write together behave as a write
    push_hit(0, 1'b1);
    req(3'd5, 8'hC0, 1'b1, 1'b1);
    chk("total_hit_count", hit_count, PERF ? 32'd24 : 32'd0);
    chk("total_miss_count", miss_count, PERF ? 32'd14 : 32'd0);
    chk("total_wb_count", wb_count, PERF ? 32'd1 : 32'd0);

    // asynchronous reset in the middle of ALLOCATE
    push_alloc(0);
    bus.set_index = 3'd6;
    req_tag       = 8'hF0;
    bus.mem_read  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.pmem_read) got = 1'b1;
    end
    if (!got) begin
      n_total++;
      $display("FAIL alloc_timeout: pmem_read never asserted");
    end
    #1 rst = 1'b1;
    #1;
    chk("async_pmem_read", 32'(bus.pmem_read), 32'd0);
    chk("async_state", 32'(state_dbg), 32'd0);
    chk("async_way_load", 32'(way_load), 32'd0);
    chk("async_miss_count", miss_count, 32'd0);
    chk("async_hit_count", hit_count, 32'd0);
    bus.mem_read = 1'b0;
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // all ways of set 3 valid and clean; cleared PLRU must choose way 0
    miss_fill(3'd3, 8'hB8, 0);
    chk("post_rst_miss_count", miss_count, PERF ? 32'd1 : 32'd0);
    chk("post_rst_wb_count", wb_count, 32'd0);

    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
